// File: rtl/smvm_stream_tx.sv
// rtl/smvm_stream_tx.sv - SMVM serial stream transmitter (vector RAM + nonzero FIFO + framing FSM)
// Define SMVM_TX_PAD_EN to append zero pairs up to a multiple of K nonzeros.
module smvm_stream_tx #(
  parameter int MAX_COLS   = 128,
  parameter int VADDR_W    = 7,
  parameter int NZ_DEPTH   = 64,
  parameter int K          = 4,
  parameter int GAP_CYCLES = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               vec_wr_en,
  input  logic [VADDR_W-1:0] vec_wr_addr,
  input  logic [7:0]         vec_wr_data,
  input  logic               nz_valid,
  output logic               nz_ready,
  input  logic [7:0]         nz_val,
  input  logic [11:0]        nz_col,
  input  logic               nz_eor,
  input  logic               nz_last,
  input  logic [11:0]        rows_cfg,
  input  logic [11:0]        cols_cfg,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic               tx_valid,
  output logic [7:0]         tx_val,
  output logic               tx_ipv,
  output logic [2:0]         tx_col
);
  localparam int AW  = $clog2(NZ_DEPTH);
  localparam int GCW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [2:0] {IDLE, HDR_R, HDR_C, VEC, NZ_V, NZ_I, GAP} state_t;

  state_t             state, state_d;
  logic [7:0]         vec_mem [MAX_COLS];
  logic [21:0]        fifo_mem [NZ_DEPTH];
  logic [AW:0]        wr_ptr, rd_ptr;
  logic [VADDR_W-1:0] cnt, cnt_d;
  logic [GCW-1:0]     gap_cnt, gap_cnt_d;
  logic [11:0]        cols_q, tx_word_d, nz_v_word;
  logic [21:0]        head;
  logic               last_seen, cur_last, full, push, pop, accept;
  logic               tx_valid_d, err_d, done_d;
`ifdef SMVM_TX_PAD_EN
  localparam int KW = (K > 1) ? $clog2(K) : 1;
  logic [KW-1:0]      grp, grp_d;
  logic               padding, padding_d;
`endif

  // FIFO entry layout: {last, eor, col[11:0], val[7:0]}
  assign head      = fifo_mem[rd_ptr[AW-1:0]];
  assign nz_v_word = {head[7:0], head[20], 3'b000};
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign nz_ready  = rst_n && !full && !last_seen;
  assign push      = nz_valid && nz_ready;
  assign busy      = (state != IDLE);
  assign accept    = start && last_seen && (cols_cfg != 12'd0) && (cols_cfg <= 12'(MAX_COLS));

  always_ff @(posedge clk) begin
    if (vec_wr_en && !busy) vec_mem[vec_wr_addr] <= vec_wr_data;
    if (push) fifo_mem[wr_ptr[AW-1:0]] <= {nz_last, nz_eor, nz_col, nz_val};
  end

  // tx_* are loaded with the word of the state being entered
  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    gap_cnt_d  = gap_cnt;
    tx_valid_d = 1'b0;
    tx_word_d  = 12'd0;
    pop        = 1'b0;
    done_d     = 1'b0;
    err_d      = vec_wr_en && busy;
`ifdef SMVM_TX_PAD_EN
    grp_d      = grp;
    padding_d  = padding;
`endif
    case (state)
      IDLE: if (start) begin
        if (accept) begin
          state_d    = HDR_R;
          tx_valid_d = 1'b1;
          tx_word_d  = rows_cfg;
        end else begin
          err_d = 1'b1;
        end
      end
      HDR_R: begin
        state_d    = HDR_C;
        tx_valid_d = 1'b1;
        tx_word_d  = cols_q;
      end
      HDR_C: begin
        state_d    = VEC;
        cnt_d      = '0;
        tx_valid_d = 1'b1;
        tx_word_d  = {vec_mem[{VADDR_W{1'b0}}], 4'b0000};
      end
      VEC: begin
        tx_valid_d = 1'b1;
        if (12'(cnt) == cols_q - 12'd1) begin
          state_d   = NZ_V;
          tx_word_d = nz_v_word;
        end else begin
          cnt_d     = cnt + 1'b1;
          tx_word_d = {vec_mem[cnt + 1'b1], 4'b0000};
        end
      end
      NZ_V: begin
        state_d    = NZ_I;
        tx_valid_d = 1'b1;
`ifdef SMVM_TX_PAD_EN
        grp_d = (grp == KW'(K - 1)) ? '0 : grp + 1'b1;
        if (!padding) begin
          tx_word_d = head[19:8];
          pop       = 1'b1;
        end
`else
        tx_word_d = head[19:8];
        pop       = 1'b1;
`endif
      end
      NZ_I: begin
`ifdef SMVM_TX_PAD_EN
        if (cur_last || padding) begin
          if (grp == '0) begin
            state_d   = GAP;
            gap_cnt_d = '0;
          end else begin
            state_d    = NZ_V;
            padding_d  = 1'b1;
            tx_valid_d = 1'b1;
          end
        end else begin
          state_d    = NZ_V;
          tx_valid_d = 1'b1;
          tx_word_d  = nz_v_word;
        end
`else
        if (cur_last) begin
          state_d   = GAP;
          gap_cnt_d = '0;
        end else begin
          state_d    = NZ_V;
          tx_valid_d = 1'b1;
          tx_word_d  = nz_v_word;
        end
`endif
      end
      GAP: begin
        if (gap_cnt == GCW'(GAP_CYCLES - 1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
`ifdef SMVM_TX_PAD_EN
          grp_d     = '0;
          padding_d = 1'b0;
`endif
        end else begin
          gap_cnt_d = gap_cnt + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      gap_cnt   <= '0;
      cols_q    <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      last_seen <= 1'b0;
      cur_last  <= 1'b0;
      tx_valid  <= 1'b0;
      tx_val    <= '0;
      tx_ipv    <= 1'b0;
      tx_col    <= '0;
      err       <= 1'b0;
      done      <= 1'b0;
`ifdef SMVM_TX_PAD_EN
      grp       <= '0;
      padding   <= 1'b0;
`endif
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      gap_cnt  <= gap_cnt_d;
      tx_valid <= tx_valid_d;
      {tx_val, tx_ipv, tx_col} <= tx_word_d;
      err      <= err_d;
      done     <= done_d;
      if (state == IDLE && accept) cols_q <= cols_cfg;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr   <= rd_ptr + 1'b1;
        cur_last <= head[21];
      end
      if (push && nz_last) last_seen <= 1'b1;
      else if (done_d) last_seen <= 1'b0;
`ifdef SMVM_TX_PAD_EN
      grp      <= grp_d;
      padding  <= padding_d;
`endif
    end
  end
endmodule

// File: tb/tb_smvm_stream_tx.sv
// tb/tb_smvm_stream_tx.sv - directed self-checking bench for smvm_stream_tx
// Expectations follow SMVM_TX_PAD_EN when the bench is built with it.
module tb_smvm_stream_tx;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        vec_wr_en;
  logic [6:0]  vec_wr_addr;
  logic [7:0]  vec_wr_data;
  logic        nz_valid, nz_ready;
  logic [7:0]  nz_val;
  logic [11:0] nz_col;
  logic        nz_eor, nz_last;
  logic [11:0] rows_cfg, cols_cfg;
  logic        start, busy, done, err;
  logic        tx_valid;
  logic [7:0]  tx_val;
  logic        tx_ipv;
  logic [2:0]  tx_col;

  int total = 0;
  int bad   = 0;

  logic [11:0] cap_words [$];
  int          cap_gap;
  logic        cap_done, cap_busy0, cap_err;
  logic [11:0] exp1 [$];

  smvm_stream_tx dut (
    .clk(clk), .rst_n(rst_n),
    .vec_wr_en(vec_wr_en), .vec_wr_addr(vec_wr_addr), .vec_wr_data(vec_wr_data),
    .nz_valid(nz_valid), .nz_ready(nz_ready), .nz_val(nz_val), .nz_col(nz_col),
    .nz_eor(nz_eor), .nz_last(nz_last),
    .rows_cfg(rows_cfg), .cols_cfg(cols_cfg), .start(start),
    .busy(busy), .done(done), .err(err),
    .tx_valid(tx_valid), .tx_val(tx_val), .tx_ipv(tx_ipv), .tx_col(tx_col)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] get_word(input int idx);
    if (idx < cap_words.size()) return cap_words[idx];
    return 12'hxxx;
  endfunction

  task automatic write_vec(input logic [6:0] a, input logic [7:0] d);
    vec_wr_en = 1'b1; vec_wr_addr = a; vec_wr_data = d;
    @(negedge clk);
    vec_wr_en = 1'b0;
  endtask

  task automatic push_nz(input logic [7:0] v, input logic [11:0] c, input logic e, input logic l);
    nz_valid = 1'b1; nz_val = v; nz_col = c; nz_eor = e; nz_last = l;
    @(negedge clk);
    nz_valid = 1'b0; nz_last = 1'b0;
  endtask

  task automatic load_job1_nz();
    push_nz(8'h05, 12'd0, 1'b0, 1'b0);
    push_nz(8'h07, 12'd2, 1'b1, 1'b0);
    push_nz(8'hFF, 12'd1, 1'b0, 1'b0);
    push_nz(8'h04, 12'd0, 1'b1, 1'b1);
  endtask

  task automatic load_job1();
    write_vec(7'd0, 8'h01);
    write_vec(7'd1, 8'hFE);
    write_vec(7'd2, 8'h03);
    load_job1_nz();
  endtask

  // Pulses start, then records every tx word until done; optional vec write at sample inj_at.
  task automatic run_job(input logic [11:0] rows, input logic [11:0] cols, input int inj_at);
    rows_cfg = rows; cols_cfg = cols; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cap_words.delete(); cap_gap = 0; cap_done = 1'b0; cap_busy0 = busy; cap_err = 1'b0;
    for (int i = 0; i < 400 && !cap_done; i++) begin
      if (i == inj_at + 1) begin cap_err = err; vec_wr_en = 1'b0; end
      if (done) cap_done = 1'b1;
      else if (tx_valid) cap_words.push_back({tx_val, tx_ipv, tx_col});
      else cap_gap++;
      if (i == inj_at) begin vec_wr_en = 1'b1; vec_wr_addr = 7'd0; vec_wr_data = 8'h55; end
      if (!cap_done) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL reset_tx_valid got=%b want=0", tx_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if ({done, err} !== 2'b00) begin bad++; $display("FAIL reset_done_err got=%b want=00", {done, err}); end
    total++; if (nz_ready !== 1'b0) begin bad++; $display("FAIL reset_nz_ready_low got=%b want=0", nz_ready); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++; if (nz_ready !== 1'b1) begin bad++; $display("FAIL reset_nz_ready_high got=%b want=1", nz_ready); end
    @(negedge clk);
  endtask

  task automatic check_job1(input string tag);
    total++; if (cap_words.size() != exp1.size()) begin bad++; $display("FAIL %s_len got=%0d want=%0d", tag, cap_words.size(), exp1.size()); end
    for (int i = 0; i < exp1.size(); i++) begin
      total++; if (get_word(i) !== exp1[i]) begin bad++; $display("FAIL %s_word%0d got=%h want=%h", tag, i, get_word(i), exp1[i]); end
    end
    total++; if (cap_gap != 8) begin bad++; $display("FAIL %s_gap got=%0d want=8", tag, cap_gap); end
    total++; if (cap_done !== 1'b1) begin bad++; $display("FAIL %s_done got=%b want=1", tag, cap_done); end
  endtask

  task automatic test_basic_job();
    load_job1();
    total++; if (nz_ready !== 1'b0) begin bad++; $display("FAIL basic_nz_ready_after_last got=%b want=0", nz_ready); end
    run_job(12'd2, 12'd3, -10);
    total++; if (cap_busy0 !== 1'b1) begin bad++; $display("FAIL basic_busy got=%b want=1", cap_busy0); end
    check_job1("basic");
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_at_done got=%b want=0", busy); end
    total++; if (nz_ready !== 1'b1) begin bad++; $display("FAIL basic_nz_ready_at_done got=%b want=1", nz_ready); end
    @(negedge clk);
    total++; if (done !== 1'b0) begin bad++; $display("FAIL basic_done_pulse_width got=%b want=0", done); end
  endtask

  task automatic test_padding();
    logic [11:0] exp [$];
    exp = '{12'h001, 12'h001, 12'h010, 12'h010, 12'h001, 12'h028, 12'h002, 12'h030, 12'h003,
            12'h048, 12'h004, 12'h050, 12'h005, 12'h068, 12'h006};
`ifdef SMVM_TX_PAD_EN
    for (int i = 0; i < 4; i++) exp.push_back(12'h000);
`endif
    push_nz(8'd1, 12'd1, 1'b0, 1'b0);
    push_nz(8'd2, 12'd2, 1'b1, 1'b0);
    push_nz(8'd3, 12'd3, 1'b0, 1'b0);
    push_nz(8'd4, 12'd4, 1'b1, 1'b0);
    push_nz(8'd5, 12'd5, 1'b0, 1'b0);
    push_nz(8'd6, 12'd6, 1'b1, 1'b1);
    run_job(12'd1, 12'd1, -10);
    total++; if (cap_words.size() != exp.size()) begin bad++; $display("FAIL pad_len got=%0d want=%0d", cap_words.size(), exp.size()); end
    for (int i = 0; i < exp.size(); i++) begin
      total++; if (get_word(i) !== exp[i]) begin bad++; $display("FAIL pad_word%0d got=%h want=%h", i, get_word(i), exp[i]); end
    end
    total++; if (cap_gap != 8) begin bad++; $display("FAIL pad_gap got=%0d want=8", cap_gap); end
    @(negedge clk);
  endtask

  task automatic test_start_reject();
    int exp_len;
    rows_cfg = 12'd1; cols_cfg = 12'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    total++; if (err !== 1'b1) begin bad++; $display("FAIL rej_empty_err got=%b want=1", err); end
    total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL rej_empty_tx_valid got=%b want=0", tx_valid); end
    @(negedge clk);
    total++; if (err !== 1'b0) begin bad++; $display("FAIL rej_err_width got=%b want=0", err); end
    nz_valid = 1'b1; nz_val = 8'h09; nz_col = 12'd5; nz_eor = 1'b1; nz_last = 1'b1; start = 1'b1;
    @(negedge clk);
    nz_valid = 1'b0; nz_last = 1'b0; start = 1'b0;
    total++; if (err !== 1'b1) begin bad++; $display("FAIL rej_same_cycle_last got=%b want=1", err); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rej_same_cycle_busy got=%b want=0", busy); end
    cols_cfg = 12'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    total++; if (err !== 1'b1) begin bad++; $display("FAIL rej_cols0 got=%b want=1", err); end
    cols_cfg = 12'd129; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    total++; if ({err, tx_valid} !== 2'b10) begin bad++; $display("FAIL rej_cols129 got=%b want=10", {err, tx_valid}); end
    for (int i = 0; i < 128; i++) write_vec(7'(i), 8'(i));
    run_job(12'd1, 12'd128, -10);
    exp_len = 132;
`ifdef SMVM_TX_PAD_EN
    exp_len = 138;
`endif
    total++; if (cap_words.size() != exp_len) begin bad++; $display("FAIL cols128_len got=%0d want=%0d", cap_words.size(), exp_len); end
    total++; if (get_word(1) !== 12'h080) begin bad++; $display("FAIL cols128_hdr got=%h want=080", get_word(1)); end
    total++; if (get_word(129) !== 12'h7F0) begin bad++; $display("FAIL cols128_lastvec got=%h want=7f0", get_word(129)); end
    total++; if (get_word(130) !== 12'h098) begin bad++; $display("FAIL cols128_nzv got=%h want=098", get_word(130)); end
    total++; if (get_word(131) !== 12'h005) begin bad++; $display("FAIL cols128_nzi got=%h want=005", get_word(131)); end
    @(negedge clk);
  endtask

  task automatic test_fifo_full();
    for (int i = 0; i < 63; i++) push_nz(8'(i), 12'(i), 1'b0, 1'b0);
    total++; if (nz_ready !== 1'b1) begin bad++; $display("FAIL full_63_ready got=%b want=1", nz_ready); end
    push_nz(8'h3F, 12'd63, 1'b0, 1'b0);
    total++; if (nz_ready !== 1'b0) begin bad++; $display("FAIL full_64_ready got=%b want=0", nz_ready); end
    rst_n = 1'b0;
    #1;
    total++; if (nz_ready !== 1'b0) begin bad++; $display("FAIL full_reset_ready got=%b want=0", nz_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++; if (nz_ready !== 1'b1) begin bad++; $display("FAIL full_after_reset_ready got=%b want=1", nz_ready); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_job();
    load_job1();
    rows_cfg = 12'd2; cols_cfg = 12'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (tx_valid !== 1'b1) begin bad++; $display("FAIL midrst_in_vec got=%b want=1", tx_valid); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL midrst_tx_valid got=%b want=0", tx_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b want=0", busy); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++; if (nz_ready !== 1'b1) begin bad++; $display("FAIL midrst_nz_ready got=%b want=1", nz_ready); end
    @(negedge clk);
    load_job1_nz();
    run_job(12'd2, 12'd3, -10);
    check_job1("midrst_rerun");
    @(negedge clk);
  endtask

  task automatic test_vec_write_busy();
    load_job1_nz();
    run_job(12'd2, 12'd3, 5);
    total++; if (cap_err !== 1'b1) begin bad++; $display("FAIL busywr_err got=%b want=1", cap_err); end
    check_job1("busywr_job");
    @(negedge clk);
    load_job1_nz();
    run_job(12'd2, 12'd3, -10);
    check_job1("busywr_readback");
  endtask

  initial begin
    vec_wr_en = 1'b0; vec_wr_addr = '0; vec_wr_data = '0;
    nz_valid = 1'b0; nz_val = '0; nz_col = '0; nz_eor = 1'b0; nz_last = 1'b0;
    rows_cfg = '0; cols_cfg = '0; start = 1'b0;
    exp1 = '{12'h002, 12'h003, 12'h010, 12'hFE0, 12'h030, 12'h050, 12'h000,
             12'h078, 12'h002, 12'hFF0, 12'h001, 12'h048, 12'h000};
    test_reset();
    test_basic_job();
    test_padding();
    test_start_reject();
    test_fifo_full();
    test_reset_mid_job();
    test_vec_write_busy();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
